mat_mult_stream: RTL and testbench
==================================

MAT_MULT_STREAM -- requirements
Module: mat_mult_stream

Interface
REQ-001 Parameter N, 4, vector length (products summed per output).
REQ-002 Parameter AW, 9, width of each unsigned A element.
REQ-003 Parameter BW, 8, width of each signed two's-complement B element (Q1.(BW-1)).
REQ-004 Parameter OW, 11, width of signed result.
REQ-005 Parameters ROWS, 4 and COLS, 4: result-matrix dimensions used for index tagging.
REQ-006 Port clk_80, input, 1, single clock; all logic on its rising edge.
REQ-007 Port rst_80, input, 1, reset, asynchronous and active-low.
REQ-008 Port a_vec, input, N*AW, packed A row; element k at bits [k*AW +: AW].
REQ-009 Port b_vec, input, N*BW, packed B column; element k at bits [k*BW +: BW].
REQ-010 Port in_valid, input, 1; port in_ready, output, 1: input handshake.
REQ-011 Port result, output, OW, signed dot product; port out_valid, output, 1; port out_ready, input, 1: output handshake.
REQ-012 Ports row_idx, output, clog2(ROWS); col_idx, output, clog2(COLS); last, output, 1: tags of the current result.

Function
REQ-013 Input accepted on a rising edge with in_valid && in_ready; output transferred on a rising edge with out_valid && out_ready.
REQ-014 Pipeline enable en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-015 Stage 1 SHALL register N products a_k * b_k, zero-extended A times sign-extended B, width AW+BW+1.
REQ-016 Stage 2 SHALL register the full-precision signed sum, width AW+BW+1+clog2(N), with no overflow.
REQ-017 Stage 3 SHALL add 2^(BW-2) and arithmetic-shift right by BW-1 (round half up), reduce to OW per REQ-026/027, and register into result.
REQ-018 Latency SHALL be exactly 3 enabled cycles from acceptance to out_valid; throughput one result per cycle while out_ready is high.
REQ-019 Each stage SHALL carry a valid bit; with en low every stage and result SHALL hold; no data lost or duplicated.
REQ-020 Bubbles (in_valid low while en high) SHALL propagate as invalid stages.
REQ-021 Position counters (row, col) SHALL advance on each output transfer: col increments, wraps COLS-1 -> 0 with row increment; row wraps ROWS-1 -> 0.
REQ-022 row_idx/col_idx SHALL show the counters; last SHALL be high iff out_valid and row=ROWS-1 and col=COLS-1.
REQ-023 Simultaneous output transfer and input acceptance in one cycle SHALL both complete.

Reset
REQ-024 rst_80 low SHALL immediately clear all stage valid bits, out_valid, result, row and col counters to 0, including mid-operation; in-flight data discarded.
REQ-025 After rst_80 rises, in_ready SHALL be high on the first cycle.

Configuration
REQ-026 With MAT_MULT_SAT_EN defined, stage 3 SHALL saturate to [-2^(OW-1), 2^(OW-1)-1].
REQ-027 Without MAT_MULT_SAT_EN, stage 3 SHALL keep the low OW bits (two's-complement wrap); no saturation logic present.

Structure
REQ-028 Package mat_mult_pkg SHALL hold default constants (N, AW, BW, OW, ROWS, COLS) and a function computing the sum width.
REQ-029 One sub-module dot_stage (stages 1-2, multiply and adder tree with enable) SHALL be instantiated; rounding, saturation, handshake and counters in the top.

Verification
REQ-030 A=[10,20,30,40], B=[13,77,102,205] -> result 21 three cycles later, row_idx 0, col_idx 0.
REQ-031 Same A, four columns B=[13,77,102,205],[26,166,90,38],[38,154,77,230],[192,115,64,13] back-to-back -> four results on consecutive cycles, first two 21 and 21, col_idx 0..3.
REQ-032 A=[511]*4, B=[127]*4 -> 1023 with MAT_MULT_SAT_EN, -20 without; A=[511]*4, B=[128]*4 -> -1024 with macro.
REQ-033 out_ready low 3 cycles during stream -> result stable, in_ready low, all 16 results of 4x4 delivered in order, last high only on 16th.
REQ-034 rst_80 low mid-stream -> out_valid 0 asynchronously, counters 0; next result tagged row 0, col 0.

Source files
------------

// File: rtl/mat_mult_pkg.sv
// Shared defaults and width helpers for the streaming dot-product block.
package mat_mult_pkg;
  localparam int MM_N    = 4;
  localparam int MM_AW   = 9;
  localparam int MM_BW   = 8;
  localparam int MM_OW   = 11;
  localparam int MM_ROWS = 4;
  localparam int MM_COLS = 4;

  // Full-precision width of the sum of n (unsigned aw x signed bw) products.
  function automatic int sum_w(input int n, input int aw, input int bw);
    return aw + bw + 1 + $clog2(n);
  endfunction
endpackage

// File: rtl/mat_mult_stream_dot_stage.sv
// dot_stage: registered lane products (stage 1) and registered full-precision sum (stage 2).
module dot_stage
  import mat_mult_pkg::*;
#(
  parameter int N  = MM_N,
  parameter int AW = MM_AW,
  parameter int BW = MM_BW,
  parameter int PW = AW + BW + 1,
  parameter int SW = sum_w(N, AW, BW)
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [N*AW-1:0] a_vec,
  input  logic [N*BW-1:0] b_vec,
  output logic [SW-1:0] sum,
  output logic          sum_valid
);
  localparam int STAGES = 2;

  logic [STAGES:1]      vld_pipe;
  logic [N-1:0][PW-1:0] prod_d, prod_q;
  logic [SW-1:0]        sum_d, sum_q;

  // Both operands are widened to PW so the truncated product is the exact signed result.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [PW-1:0] a_ext, b_ext;
    assign a_ext     = PW'(a_vec[k*AW +: AW]);
    assign b_ext     = PW'($signed(b_vec[k*BW +: BW]));
    assign prod_d[k] = a_ext * b_ext;
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N; k++) sum_d = sum_d + SW'($signed(prod_q[k]));
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      vld_pipe <= '0;
      prod_q   <= '0;
      sum_q    <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      prod_q   <= prod_d;
      sum_q    <= sum_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = vld_pipe[STAGES];
endmodule

// File: rtl/mat_mult_stream.sv
// mat_mult_stream: 3-stage streaming dot product with round-half-up, row/col tagging.
// Define MAT_MULT_SAT_EN to saturate the result; otherwise it wraps to OW bits.
module mat_mult_stream
  import mat_mult_pkg::*;
#(
  parameter int N    = MM_N,
  parameter int AW   = MM_AW,
  parameter int BW   = MM_BW,
  parameter int OW   = MM_OW,
  parameter int ROWS = MM_ROWS,
  parameter int COLS = MM_COLS
) (
  input  logic                     clk_80,
  input  logic                     rst_80,
  input  logic [N*AW-1:0]          a_vec,
  input  logic [N*BW-1:0]          b_vec,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OW-1:0]            result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic [$clog2(COLS)-1:0]  col_idx,
  output logic                     last
);
  localparam int SW = sum_w(N, AW, BW);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic                 en;
  logic [SW-1:0]        sum;
  logic                 sum_valid;
  logic signed [SW:0]   rnd, shr;
  logic [OW-1:0]        res_d;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  dot_stage #(.N(N), .AW(AW), .BW(BW)) u_dot (
    .gclk      (clk_80),
    .grst_n    (rst_80),
    .en        (en),
    .in_valid  (in_valid),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .sum       (sum),
    .sum_valid (sum_valid)
  );

  // One guard bit keeps the rounding add from overflowing before the Q1.(BW-1) rescale.
  assign rnd = $signed({sum[SW-1], sum}) + $signed((SW+1)'(2**(BW-2)));
  assign shr = rnd >>> (BW-1);

`ifdef MAT_MULT_SAT_EN
  localparam logic signed [SW:0] MAX_V = (SW+1)'(2**(OW-1) - 1);
  localparam logic signed [SW:0] MIN_V = (SW+1)'(-(2**(OW-1)));
  always_comb begin
    res_d = OW'(shr);
    if (shr > MAX_V)      res_d = OW'(MAX_V);
    else if (shr < MIN_V) res_d = OW'(MIN_V);
  end
`else
  assign res_d = OW'(shr);
`endif

  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      out_valid <= 1'b0;
      result    <= '0;
      row       <= '0;
      col       <= '0;
    end else begin
      if (en) begin
        out_valid <= sum_valid;
        if (sum_valid) result <= res_d;
      end
      if (out_valid && out_ready) begin
        if (col == CW'(COLS-1)) begin
          col <= '0;
          row <= (row == RW'(ROWS-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign row_idx = row;
  assign col_idx = col;
  assign last    = out_valid && (row == RW'(ROWS-1)) && (col == CW'(COLS-1));
endmodule

// File: tb/tb_mat_mult_stream.sv
// Directed bench for mat_mult_stream: latency, streaming, saturation/wrap, stall and async reset.
module tb_mat_mult_stream;
  logic        clk_80 = 1'b0;
  logic        rst_80 = 1'b0;
  logic [35:0] a_vec  = '0;
  logic [31:0] b_vec  = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  row_idx, col_idx;
  logic        last;

  int total = 0, fails = 0, cyc = 0;
  int q_res[$], q_row[$], q_col[$], q_last[$], q_cyc[$];

  // B columns (raw 8-bit codes), A rows, and hand-computed results for the 4x4 run
  int bcol [4][4] = '{'{13, 77, 102, 205}, '{26, 166, 90, 38},
                      '{38, 154, 77, 230}, '{192, 115, 64, 13}};
  int arow [4][4] = '{'{10, 20, 30, 40}, '{0, 0, 128, 0},
                      '{0, 128, 0, 0},  '{0, 0, 0, 256}};
  int exp16 [16]  = '{21, 21, -3, 32,  102, 90, 77, 64,
                      77, -90, -102, 115,  -102, 76, -52, 26};

  mat_mult_stream dut (
    .clk_80(clk_80), .rst_80(rst_80), .a_vec(a_vec), .b_vec(b_vec),
    .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .out_valid(out_valid), .out_ready(out_ready),
    .row_idx(row_idx), .col_idx(col_idx), .last(last)
  );

  always #5 clk_80 = ~clk_80;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; log any output transfer that happens on that edge.
  task automatic tick();
    logic xfer;
    int r, ro, co, la;
    xfer = out_valid && out_ready;
    r = $signed(result); ro = int'(row_idx); co = int'(col_idx); la = int'(last);
    @(posedge clk_80); #1;
    cyc++;
    if (xfer === 1'b1) begin
      q_res.push_back(r); q_row.push_back(ro); q_col.push_back(co);
      q_last.push_back(la); q_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_q();
    q_res.delete(); q_row.delete(); q_col.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic do_reset();
    rst_80 = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_vec = '0; b_vec = '0;
    @(posedge clk_80); #1;
    rst_80 = 1'b1; #1;
    clear_q();
  endtask

  function automatic logic [35:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
  endfunction

  function automatic logic [31:0] pb(input int b0, input int b1, input int b2, input int b3);
    return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  initial begin
    int idx, held;
    logic acc;

    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_row", row_idx, 0);
    chk("rst_col", col_idx, 0);
    chk("rst_last", last, 0);
    do_reset();
    chk("in_ready_after_rst", in_ready, 1);

    // single vector, 3-cycle latency
    a_vec = pa(10, 20, 30, 40); b_vec = pb(13, 77, 102, 205); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); chk("lat_not_yet", out_valid, 0);
    tick(); chk("lat_valid", out_valid, 1);
    chk("single_res", $signed(result), 21);
    chk("single_row", row_idx, 0);
    chk("single_col", col_idx, 0);
    chk("single_last", last, 0);
    tick(); chk("col_adv", col_idx, 1);
    chk("drained", out_valid, 0);

    // four columns back-to-back
    do_reset();
    a_vec = pa(10, 20, 30, 40);
    for (int i = 0; i < 4; i++) begin
      b_vec = pb(bcol[i][0], bcol[i][1], bcol[i][2], bcol[i][3]); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 12 && q_res.size() < 4; k++) tick();
    chk("b2b_count", q_res.size(), 4);
    for (int i = 0; i < 4 && i < q_res.size(); i++) begin
      chk("b2b_res", q_res[i], exp16[i]);
      chk("b2b_col", q_col[i], i);
      if (i > 0) chk("b2b_consec", q_cyc[i] - q_cyc[i-1], 1);
    end

    // saturation / wrap corners
    do_reset();
    a_vec = pa(511, 511, 511, 511); b_vec = pb(127, 127, 127, 127); in_valid = 1'b1;
    tick();
    b_vec = pb(128, 128, 128, 128);
    tick(); in_valid = 1'b0;
    for (int k = 0; k < 10 && q_res.size() < 2; k++) tick();
    chk("corner_count", q_res.size(), 2);
    if (q_res.size() == 2) begin
`ifdef MAT_MULT_SAT_EN
      chk("sat_pos", q_res[0], 1023);
      chk("sat_neg", q_res[1], -1024);
`else
      chk("wrap_pos", q_res[0], -20);
      chk("wrap_neg", q_res[1], 4);
`endif
    end

    // full 4x4 with a 3-cycle output stall
    do_reset();
    idx = 0; held = 0;
    for (int k = 0; k < 80 && q_res.size() < 16; k++) begin
      in_valid = (idx < 16);
      if (idx < 16) begin
        a_vec = pa(arow[idx/4][0], arow[idx/4][1], arow[idx/4][2], arow[idx/4][3]);
        b_vec = pb(bcol[idx%4][0], bcol[idx%4][1], bcol[idx%4][2], bcol[idx%4][3]);
      end
      out_ready = !(k >= 6 && k < 9);
      #1;
      if (k >= 6 && k < 9) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        if (k == 6) held = $signed(result);
        else chk("stall_hold", $signed(result), held);
      end
      if (k == 9) chk("stall_hold_after", $signed(result), held);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("mat_count", q_res.size(), 16);
    for (int i = 0; i < 16 && i < q_res.size(); i++) begin
      chk("mat_res", q_res[i], exp16[i]);
      chk("mat_row", q_row[i], i / 4);
      chk("mat_col", q_col[i], i % 4);
      chk("mat_last", q_last[i], (i == 15) ? 1 : 0);
    end

    // asynchronous reset mid-stream
    do_reset();
    a_vec = pa(10, 20, 30, 40);
    for (int i = 0; i < 5; i++) begin
      b_vec = pb(bcol[i%4][0], bcol[i%4][1], bcol[i%4][2], bcol[i%4][3]); in_valid = 1'b1;
      tick();
    end
    chk("pre_rst_col", col_idx, 2);
    chk("pre_rst_valid", out_valid, 1);
    #3; rst_80 = 1'b0; #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_row", row_idx, 0);
    chk("arst_col", col_idx, 0);
    chk("arst_result", result, 0);
    in_valid = 1'b0;
    @(negedge clk_80); rst_80 = 1'b1;
    clear_q();
    b_vec = pb(bcol[1][0], bcol[1][1], bcol[1][2], bcol[1][3]); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    repeat (8) tick();
    chk("post_rst_count", q_res.size(), 1);
    if (q_res.size() >= 1) begin
      chk("post_rst_res", q_res[0], 21);
      chk("post_rst_row", q_row[0], 0);
      chk("post_rst_col", q_col[0], 0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
